onewire_pad_ctrl: RTL and testbench

Pad-side conditioning stage between the 1-Wire master core/APB wrapper and the I/O pad.
- Receive path: synchronises and deglitches the raw bus line, then feeds the filtered level back to the core's owr_i.
- Transmit path: turns the core's pull-down request into pad controls.
- Strong pull-up: a timed strong pull-up sequencer for parasitic-powered devices.
- Short detection: flags a bus held low while nobody drives it.

---
 rtl/onewire_pkg.sv | 15 +
 rtl/onewire_pad_ctrl_if.sv | 31 +++
 rtl/onewire_rx_filter.sv | 40 ++++
 rtl/onewire_pad_ctrl.sv | 122 ++++++++++++
 tb/tb_onewire_pad_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/onewire_pkg.sv
// Shared types and defaults for the 1-Wire pad-side conditioning stage.
// Holds the strong pull-up sequencer state encoding and default widths.
package onewire_pkg;

  localparam int FILT_CYCLES_DEF = 3;
  localparam int SPU_W_DEF       = 16;
  localparam int SHORT_W_DEF     = 12;

  typedef enum logic [1:0] {
    SPU_IDLE  = 2'd0,
    SPU_ARMED = 2'd1,
    SPU_ON    = 2'd2
  } spu_state_e;

endpackage

// File: rtl/onewire_pad_ctrl_if.sv
// Control/status bundle between the APB wrapper and the pad stage.
// master: wrapper (drives requests); slave: pad stage (drives status).
interface onewire_pad_ctrl_if
  import onewire_pkg::*;
#(
  parameter int SPU_W   = SPU_W_DEF,
  parameter int SHORT_W = SHORT_W_DEF
);

  logic               spu_req_i;
  logic [SPU_W-1:0]   spu_len_i;
  logic               spu_abort_i;
  logic               spu_busy_o;
  logic               spu_done_o;
  logic [SHORT_W-1:0] short_limit_i;
  logic               short_clr_i;
  logic               short_o;

  modport master (
    output spu_req_i, spu_len_i, spu_abort_i,
    output short_limit_i, short_clr_i,
    input  spu_busy_o, spu_done_o, short_o
  );

  modport slave (
    input  spu_req_i, spu_len_i, spu_abort_i,
    input  short_limit_i, short_clr_i,
    output spu_busy_o, spu_done_o, short_o
  );

endinterface

// File: rtl/onewire_rx_filter.sv
// Two-flop synchroniser plus stable-count deglitch filter for a slow
// open-drain input. Ports: clk, rst_n, din (async), dout (filtered).
module onewire_rx_filter #(
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILT_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] fcnt;

  // Idle bus is high, so the chain resets high to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      fcnt <= '0;
      dout <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        fcnt <= '0;
      end else if (fcnt == LAST) begin
        dout <= s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/onewire_pad_ctrl.sv
// Pad-side stage: rx filter, pull-down, timed strong pull-up, short detect.
// Ports: PCLK/PRESETn, drive_low_i, pad_rx_i, rx_o, pad_pd_o, pad_spu_o, ctl.
module onewire_pad_ctrl
  import onewire_pkg::*;
#(
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int SPU_W       = SPU_W_DEF,
  parameter int SHORT_W     = SHORT_W_DEF
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               drive_low_i,
  input  logic               pad_rx_i,
  output logic               rx_o,
  output logic               pad_pd_o,
  output logic               pad_spu_o,
  onewire_pad_ctrl_if.slave  ctl
);

  spu_state_e         state;
  spu_state_e         state_n;
  logic [SPU_W-1:0]   scnt;
  logic [SPU_W-1:0]   scnt_n;
  logic               spu_q;
  logic               spu_n;
  logic               done_q;
  logic               done_n;
  logic [SHORT_W-1:0] kcnt;
  logic               kcond;
  logic               khit;

  onewire_rx_filter #(
    .FILT_CYCLES (FILT_CYCLES)
  ) u_rx_filter (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .din   (pad_rx_i),
    .dout  (rx_o)
  );

  assign pad_pd_o  = drive_low_i;
  // Combinational gate so pull-down and pull-up never overlap.
  assign pad_spu_o = spu_q & ~drive_low_i;

  assign ctl.spu_busy_o = (state != SPU_IDLE);
  assign ctl.spu_done_o = done_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= SPU_IDLE;
      scnt   <= '0;
      spu_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      scnt   <= scnt_n;
      spu_q  <= spu_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    spu_n   = spu_q;
    done_n  = 1'b0;
    unique case (state)
      SPU_IDLE: begin
        if (ctl.spu_req_i && (ctl.spu_len_i != '0)) begin
          state_n = SPU_ARMED;
          scnt_n  = ctl.spu_len_i;
        end
      end
      SPU_ARMED: begin
        if (ctl.spu_abort_i) begin
          state_n = SPU_IDLE;
          done_n  = 1'b1;
        end else if (!drive_low_i) begin
          state_n = SPU_ON;
          spu_n   = 1'b1;
        end
      end
      SPU_ON: begin
        scnt_n = scnt - 1'b1;
        // Abort, a new pull-down, or the last cycle all end in one pulse.
        if (ctl.spu_abort_i || drive_low_i ||
            (scnt == SPU_W'(1))) begin
          state_n = SPU_IDLE;
          spu_n   = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = SPU_IDLE;
        spu_n   = 1'b0;
      end
    endcase
  end

  assign kcond = (state == SPU_IDLE) & ~drive_low_i & ~rx_o &
                 (ctl.short_limit_i != '0);
  assign khit  = kcond & (kcnt == ctl.short_limit_i - 1'b1);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      kcnt        <= '0;
      ctl.short_o <= 1'b0;
    end else begin
      if (kcond) begin
        kcnt <= (&kcnt) ? kcnt : kcnt + 1'b1;
      end else begin
        kcnt <= '0;
      end
      if (khit) begin
        ctl.short_o <= 1'b1;
      end else if (ctl.short_clr_i) begin
        ctl.short_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onewire_pad_ctrl.sv
// Self-checking bench for onewire_pad_ctrl: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_onewire_pad_ctrl;
  import onewire_pkg::*;

  localparam int FILT    = 3;
  localparam int SPU_W   = 16;
  localparam int SHORT_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drive_low = 1'b0;
  logic pad_rx = 1'b0;
  logic rx;
  logic pad_pd;
  logic pad_spu;

  onewire_pad_ctrl_if #(.SPU_W(SPU_W), .SHORT_W(SHORT_W)) ctl ();

  onewire_pad_ctrl #(
    .FILT_CYCLES (FILT),
    .SPU_W       (SPU_W),
    .SHORT_W     (SHORT_W)
  ) dut (
    .PCLK        (clk),
    .PRESETn     (rst_n),
    .drive_low_i (drive_low),
    .pad_rx_i    (pad_rx),
    .rx_o        (rx),
    .pad_pd_o    (pad_pd),
    .pad_spu_o   (pad_spu),
    .ctl         (ctl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Reference model state
  bit m_s1, m_s2, m_rx;
  bit hist [FILT];
  bit m_armed;
  int m_len, m_left;
  bit m_done;
  int m_run;
  bit m_short;

  int rx_low_cnt, spu_hi_cnt, done_cnt;

  function automatic void model_reset();
    m_s1 = 1; m_s2 = 1; m_rx = 1;
    for (int i = 0; i < FILT; i++) hist[i] = 1;
    m_armed = 0; m_len = 0; m_left = 0; m_done = 0;
    m_run = 0; m_short = 0;
  endfunction

  function automatic void model_edge();
    bit busy_old = m_armed || (m_left > 0);
    bit rx_old = m_rx;
    bit all_flip = 1;
    int lim = int'(ctl.short_limit_i);
    // filtered level flips once FILT synced samples in a row differ
    for (int i = FILT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = m_s2;
    for (int i = 0; i < FILT; i++) if (hist[i] == m_rx) all_flip = 0;
    if (all_flip) m_rx = ~m_rx;
    m_s2 = m_s1;
    m_s1 = pad_rx;
    // short: flag once the released-low run reaches the limit
    if (!busy_old && !drive_low && !rx_old && lim != 0) begin
      m_run++;
      if (m_run == lim) m_short = 1;
      else if (ctl.short_clr_i) m_short = 0;
    end else begin
      m_run = 0;
      if (ctl.short_clr_i) m_short = 0;
    end
    // strong pull-up
    m_done = 0;
    if (m_left > 0) begin
      if (ctl.spu_abort_i || drive_low || m_left == 1) begin
        m_left = 0; m_done = 1;
      end else begin
        m_left--;
      end
    end else if (m_armed) begin
      if (ctl.spu_abort_i) begin
        m_armed = 0; m_done = 1;
      end else if (!drive_low) begin
        m_armed = 0; m_left = m_len;
      end
    end else if (ctl.spu_req_i && ctl.spu_len_i != 0) begin
      m_armed = 1; m_len = int'(ctl.spu_len_i);
    end
  endfunction

  task automatic compare_all();
    check("rx_o", rx, m_rx);
    check("pad_pd_o", pad_pd, drive_low);
    check("pad_spu_o", pad_spu, (m_left > 0) && !drive_low);
    check("spu_busy_o", ctl.spu_busy_o, m_armed || (m_left > 0));
    check("spu_done_o", ctl.spu_done_o, m_done);
    check("short_o", ctl.short_o, m_short);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
    if (!rx) rx_low_cnt++;
    if (pad_spu) spu_hi_cnt++;
    if (ctl.spu_done_o) done_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=0 want=1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    ctl.spu_req_i = 0; ctl.spu_len_i = '0; ctl.spu_abort_i = 0;
    ctl.short_limit_i = '0; ctl.short_clr_i = 0;
    drive_low = 1; pad_rx = 0; rst_n = 0;
    @(negedge clk); @(negedge clk);
    check("rst_rx", rx, 1);
    check("rst_spu", pad_spu, 0);
    check("rst_short", ctl.short_o, 0);
    check("rst_busy", ctl.spu_busy_o, 0);
    check("rst_done", ctl.spu_done_o, 0);
    check("rst_pd", pad_pd, 1);
    drive_low = 0;
    model_reset();
    rst_n = 1;

    // reset release with pad low: rx falls after 5 edges
    repeat (4) step();
    check("rx_lat4", rx, 1);
    step();
    check("rx_lat5", rx, 0);

    // glitch rejection
    pad_rx = 1; repeat (8) step();
    rx_low_cnt = 0;
    pad_rx = 0; step(); pad_rx = 1; repeat (8) step();
    pad_rx = 0; repeat (2) step(); pad_rx = 1; repeat (8) step();
    check("glitch12", rx_low_cnt, 0);
    rx_low_cnt = 0;
    pad_rx = 0; repeat (3) step(); pad_rx = 1; repeat (10) step();
    check("glitch3", rx_low_cnt, 3);

    // strong pull-up, normal run
    drive_low = 1;
    ctl.spu_req_i = 1; ctl.spu_len_i = 16'd10;
    step();
    ctl.spu_req_i = 0; ctl.spu_len_i = '0;
    check("armed_busy", ctl.spu_busy_o, 1);
    repeat (3) step();
    check("armed_spu", pad_spu, 0);
    spu_hi_cnt = 0; done_cnt = 0;
    drive_low = 0;
    repeat (15) step();
    check("spu_len10", spu_hi_cnt, 10);
    check("spu_done1", done_cnt, 1);
    check("spu_idle", ctl.spu_busy_o, 0);

    // abort by pull-down while ON
    ctl.spu_req_i = 1; ctl.spu_len_i = 16'd20;
    step();
    ctl.spu_req_i = 0;
    repeat (5) step();
    drive_low = 1;
    #1;
    check("spu_comb_off", pad_spu, 0);
    check("spu_still_busy", ctl.spu_busy_o, 1);
    done_cnt = 0;
    step();
    check("drv_abort_idle", ctl.spu_busy_o, 0);
    drive_low = 0;
    step();
    check("drv_abort_done", done_cnt, 1);

    // abort while ARMED
    drive_low = 1;
    ctl.spu_req_i = 1; ctl.spu_len_i = 16'd8;
    step();
    ctl.spu_req_i = 0; ctl.spu_abort_i = 1;
    step();
    ctl.spu_abort_i = 0;
    check("armed_abort_busy", ctl.spu_busy_o, 0);
    check("armed_abort_done", ctl.spu_done_o, 1);
    drive_low = 0;

    // zero length request is ignored
    done_cnt = 0;
    ctl.spu_req_i = 1; ctl.spu_len_i = '0;
    step();
    ctl.spu_req_i = 0;
    check("zero_busy", ctl.spu_busy_o, 0);
    step();
    check("zero_done", done_cnt, 0);

    // second request while ON does not change the length
    spu_hi_cnt = 0; done_cnt = 0;
    ctl.spu_req_i = 1; ctl.spu_len_i = 16'd6;
    step();
    ctl.spu_req_i = 0;
    step();
    ctl.spu_req_i = 1; ctl.spu_len_i = 16'd30;
    step();
    ctl.spu_req_i = 0;
    repeat (15) step();
    check("rereq_len", spu_hi_cnt, 6);
    check("rereq_done", done_cnt, 1);

    // short detect
    ctl.short_limit_i = 12'd20;
    pad_rx = 0;
    n = 0;
    while (rx && n < 20) begin step(); n++; end
    check("short_rx_fall", rx, 0);
    n = 0;
    while (!ctl.short_o && n < 100) begin step(); n++; end
    check("short_lat", n, 20);
    pad_rx = 1; repeat (10) step();
    check("short_sticky", ctl.short_o, 1);
    ctl.short_clr_i = 1; step(); ctl.short_clr_i = 0;
    check("short_clr", ctl.short_o, 0);
    ctl.short_limit_i = '0;
    pad_rx = 0; repeat (60) step();
    check("short_off", ctl.short_o, 0);
    pad_rx = 1; repeat (8) step();

    // randomized traffic
    ctl.short_limit_i = 12'd15;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) pad_rx = ~pad_rx;
      if ($urandom_range(0, 9) == 0) drive_low = ~drive_low;
      ctl.spu_req_i = ($urandom_range(0, 19) == 0);
      ctl.spu_len_i = 16'($urandom_range(0, 12));
      ctl.spu_abort_i = ($urandom_range(0, 39) == 0);
      ctl.short_clr_i = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0)
        ctl.short_limit_i = 12'($urandom_range(0, 30));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
